// File: rtl/colordetect_frame_ctrl.sv
// Frame sequencer for the color-detection path: double-buffers thresholds, counts
// frame-buffer writes, waits for the detector to settle and snapshots its result.
module colordetect_frame_ctrl #(
  parameter int FRAME_PIXELS   = 230400,
  parameter int ADDR_WIDTH     = 18,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_enable,
  input  logic                  i_cfg_done,
  input  logic                  i_sof,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_result,
  input  logic [287:0]          i_ctrl_bus,
  input  logic                  i_ctrl_update,
  output logic [287:0]          o_ctrl_shadow,
  output logic                  o_flush,
  output logic [31:0]           o_result,
  output logic                  o_result_valid,
  input  logic                  i_result_ack,
  output logic [15:0]           o_frame_count,
  output logic [3:0]            o_error,
  input  logic                  i_err_clr,
  output logic                  o_busy
);

  localparam int PW        = $clog2(FRAME_PIXELS + 1);
  localparam int GW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PHASE_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int CW        = $clog2(PHASE_MAX + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_FLUSH  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_LATCH  = 3'd5;

  logic [2:0]    state, state_next;
  logic [PW-1:0] pix, pix_next;
  logic [GW-1:0] gap, gap_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pending, pending_next;
  logic [287:0]  shadow_next;
  logic          flush_next;
  logic [31:0]   result_next;
  logic          valid_next;
  logic [15:0]   frame_next;
  logic [3:0]    new_err;
  logic [3:0]    error_next;
  logic          busy_next;
  logic          commit;

  always_comb begin
    state_next   = state;
    pix_next     = pix;
    gap_next     = gap;
    cnt_next     = cnt;
    pending_next = pending;
    shadow_next  = o_ctrl_shadow;
    flush_next   = o_flush;
    result_next  = o_result;
    valid_next   = o_result_valid;
    frame_next   = o_frame_count;
    new_err      = '0;
    commit       = 1'b0;

    if (i_ctrl_update) pending_next = 1'b1;
    // A LATCH in the same cycle re-asserts valid below, so latch beats ack.
    if (i_result_ack) valid_next = 1'b0;

    if (!i_enable) begin
      state_next = ST_IDLE;
      flush_next = 1'b0;
      pix_next   = '0;
      gap_next   = '0;
      cnt_next   = '0;
      if (state == ST_IDLE && i_ctrl_update) begin
        shadow_next  = i_ctrl_bus;
        pending_next = 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_ctrl_update) begin
            shadow_next  = i_ctrl_bus;
            pending_next = 1'b0;
          end
          if (i_cfg_done) state_next = ST_ARM;
        end
        ST_ARM: begin
          if (i_sof) begin
            commit     = 1'b1;
            state_next = ST_FLUSH;
            flush_next = 1'b1;
            cnt_next   = '0;
            pix_next   = '0;
            gap_next   = '0;
          end
        end
        ST_FLUSH: begin
          pix_next = '0;
          gap_next = '0;
          if (cnt == CW'(FLUSH_CYCLES - 1)) begin
            state_next = ST_RUN;
            flush_next = 1'b0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (i_sof) begin
            new_err[1] = 1'b1;
            commit     = 1'b1;
            state_next = ST_FLUSH;
            flush_next = 1'b1;
            cnt_next   = '0;
            pix_next   = '0;
            gap_next   = '0;
          end else if (i_valid) begin
            gap_next = '0;
            pix_next = pix + PW'(1);
            if (i_addr != ADDR_WIDTH'(pix)) new_err[2] = 1'b1;
            if (pix == PW'(FRAME_PIXELS - 1)) begin
              state_next = ST_SETTLE;
              cnt_next   = '0;
            end
          end else if (gap == GW'(TIMEOUT_CYCLES - 1)) begin
            new_err[0] = 1'b1;
            state_next = ST_ARM;
            gap_next   = '0;
          end else begin
            gap_next = gap + GW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            state_next = ST_LATCH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        ST_LATCH: begin
          result_next = i_result;
          valid_next  = 1'b1;
          frame_next  = o_frame_count + 16'd1;
          if (o_result_valid && !i_result_ack) new_err[3] = 1'b1;
          state_next  = ST_ARM;
        end
        default: state_next = ST_IDLE;
      endcase

      // An update coinciding with the commit counts as pending and takes the live bus.
      if (commit && (pending || i_ctrl_update)) begin
        shadow_next  = i_ctrl_bus;
        pending_next = 1'b0;
      end
    end
  end

  assign error_next = (i_err_clr ? 4'b0000 : o_error) | new_err;
  assign busy_next  = (state_next == ST_FLUSH) || (state_next == ST_RUN) ||
                      (state_next == ST_SETTLE) || (state_next == ST_LATCH);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state          <= ST_IDLE;
      pix            <= '0;
      gap            <= '0;
      cnt            <= '0;
      pending        <= 1'b0;
      o_ctrl_shadow  <= '0;
      o_flush        <= 1'b0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_frame_count  <= '0;
      o_error        <= '0;
      o_busy         <= 1'b0;
    end else begin
      state          <= state_next;
      pix            <= pix_next;
      gap            <= gap_next;
      cnt            <= cnt_next;
      pending        <= pending_next;
      o_ctrl_shadow  <= shadow_next;
      o_flush        <= flush_next;
      o_result       <= result_next;
      o_result_valid <= valid_next;
      o_frame_count  <= frame_next;
      o_error        <= error_next;
      o_busy         <= busy_next;
    end
  end

endmodule

// File: tb/tb_colordetect_frame_ctrl.sv
// Directed bench for colordetect_frame_ctrl: nominal frame, threshold commit,
// short frame, timeout, address order, overrun, enable drop and async reset.
module tb_colordetect_frame_ctrl;

  logic          i_clk;
  logic          i_rstn;
  logic          i_enable;
  logic          i_cfg_done;
  logic          i_sof;
  logic          i_valid;
  logic [17:0]   i_addr;
  logic [31:0]   i_result;
  logic [287:0]  i_ctrl_bus;
  logic          i_ctrl_update;
  logic [287:0]  o_ctrl_shadow;
  logic          o_flush;
  logic [31:0]   o_result;
  logic          o_result_valid;
  logic          i_result_ack;
  logic [15:0]   o_frame_count;
  logic [3:0]    o_error;
  logic          i_err_clr;
  logic          o_busy;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  localparam logic [287:0] BUS_A = {9{32'hA5A5_0001}};
  localparam logic [287:0] BUS_B = {9{32'h5A5A_1234}};

  colordetect_frame_ctrl #(
    .FRAME_PIXELS(16), .ADDR_WIDTH(18), .FLUSH_CYCLES(2),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_cfg_done(i_cfg_done),
    .i_sof(i_sof), .i_valid(i_valid), .i_addr(i_addr), .i_result(i_result),
    .i_ctrl_bus(i_ctrl_bus), .i_ctrl_update(i_ctrl_update), .o_ctrl_shadow(o_ctrl_shadow),
    .o_flush(o_flush), .o_result(o_result), .o_result_valid(o_result_valid),
    .i_result_ack(i_result_ack), .o_frame_count(o_frame_count), .o_error(o_error),
    .i_err_clr(i_err_clr), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pixel(input int addr);
    i_valid = 1'b1;
    i_addr  = 18'(addr);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic start_frame();
    i_sof = 1'b1;
    tick();
    i_sof = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_err_clr();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0; i_enable = 1'b0; i_cfg_done = 1'b0; i_sof = 1'b0;
    i_valid = 1'b0; i_addr = '0; i_result = '0; i_ctrl_bus = '0;
    i_ctrl_update = 1'b0; i_result_ack = 1'b0; i_err_clr = 1'b0;
    #12;
    check("rst_shadow", o_ctrl_shadow, '0);
    check("rst_flush", {287'd0, o_flush}, 288'd0);
    check("rst_result", {256'd0, o_result}, 288'd0);
    check("rst_valid", {287'd0, o_result_valid}, 288'd0);
    check("rst_frame", {272'd0, o_frame_count}, 288'd0);
    check("rst_error", {284'd0, o_error}, 288'd0);
    check("rst_busy", {287'd0, o_busy}, 288'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    tick();

    // 1. Nominal frame
    i_ctrl_bus = BUS_A; i_ctrl_update = 1'b1;
    tick();
    i_ctrl_update = 1'b0;
    check("idle_shadow_load", o_ctrl_shadow, BUS_A);
    i_enable = 1'b1; i_cfg_done = 1'b1;
    tick();
    check("arm_busy", {287'd0, o_busy}, 288'd0);
    i_sof = 1'b1;
    tick();
    i_sof = 1'b0;
    check("flush_c1", {287'd0, o_flush}, 288'd1);
    check("busy_flush", {287'd0, o_busy}, 288'd1);
    tick();
    check("flush_c2", {287'd0, o_flush}, 288'd1);
    tick();
    check("flush_end", {287'd0, o_flush}, 288'd0);
    i_result = 32'hDEADBEE0;
    for (int i = 0; i < 16; i++) pixel(i);
    for (int k = 1; k <= 4; k++) tick();
    check("valid_early", {287'd0, o_result_valid}, 288'd0);
    tick();
    check("valid_6cyc", {287'd0, o_result_valid}, 288'd1);
    check("result1", {256'd0, o_result}, {256'd0, 32'hDEADBEE0});
    check("frame1", {272'd0, o_frame_count}, 288'd1);
    check("error1", {284'd0, o_error}, 288'd0);
    check("busy_arm1", {287'd0, o_busy}, 288'd0);

    // 2. Threshold commit deferred to next sof
    i_result_ack = 1'b1;
    tick();
    i_result_ack = 1'b0;
    check("ack_clears", {287'd0, o_result_valid}, 288'd0);
    start_frame();
    for (int i = 0; i < 5; i++) pixel(i);
    i_ctrl_bus = BUS_B; i_ctrl_update = 1'b1;
    pixel(5);
    i_ctrl_update = 1'b0;
    check("shadow_held_run", o_ctrl_shadow, BUS_A);
    for (int i = 6; i < 16; i++) pixel(i);
    for (int k = 1; k <= 5; k++) tick();
    check("frame2", {272'd0, o_frame_count}, 288'd2);
    check("shadow_held_latch", o_ctrl_shadow, BUS_A);
    i_result_ack = 1'b1;
    tick();
    i_result_ack = 1'b0;
    i_sof = 1'b1;
    tick();
    i_sof = 1'b0;
    check("shadow_commit", o_ctrl_shadow, BUS_B);

    // 3. Short frame, then timeout
    tick();
    tick();
    for (int i = 0; i < 10; i++) pixel(i);
    i_sof = 1'b1;
    tick();
    i_sof = 1'b0;
    check("short_err", {284'd0, o_error}, {284'd0, 4'b0010});
    check("short_reflush", {287'd0, o_flush}, 288'd1);
    pulse_err_clr();
    check("err_clr", {284'd0, o_error}, 288'd0);
    tick();
    for (int i = 0; i < 5; i++) pixel(i);
    for (int k = 1; k <= 49; k++) tick();
    check("timeout_not_yet", {284'd0, o_error}, 288'd0);
    check("timeout_busy", {287'd0, o_busy}, 288'd1);
    tick();
    check("timeout_err", {284'd0, o_error}, {284'd0, 4'b0001});
    check("timeout_arm", {287'd0, o_busy}, 288'd0);

    // 4. Address order, overrun, ack during latch
    pulse_err_clr();
    check("err_clr2", {284'd0, o_error}, 288'd0);
    start_frame();
    i_result = 32'h11111110;
    for (int i = 0; i < 16; i++) begin
      pixel((i == 2) ? 3 : i);
      if (i == 2) check("order_err", {284'd0, o_error}, {284'd0, 4'b0100});
    end
    for (int k = 1; k <= 5; k++) tick();
    check("frame3", {272'd0, o_frame_count}, 288'd3);
    pulse_err_clr();
    start_frame();
    i_result = 32'h22222220;
    for (int i = 0; i < 16; i++) pixel(i);
    for (int k = 1; k <= 5; k++) tick();
    check("overrun_err", {284'd0, o_error}, {284'd0, 4'b1000});
    check("overrun_result", {256'd0, o_result}, {256'd0, 32'h22222220});
    check("overrun_valid", {287'd0, o_result_valid}, 288'd1);
    pulse_err_clr();
    start_frame();
    i_result = 32'h33333330;
    for (int i = 0; i < 16; i++) pixel(i);
    for (int k = 1; k <= 4; k++) tick();
    i_result_ack = 1'b1;
    tick();
    i_result_ack = 1'b0;
    check("ack_latch_valid", {287'd0, o_result_valid}, 288'd1);
    check("ack_latch_noerr", {284'd0, o_error}, 288'd0);
    check("frame5", {272'd0, o_frame_count}, 288'd5);
    check("result5", {256'd0, o_result}, {256'd0, 32'h33333330});

    // 5. Enable drop mid-RUN, then async reset mid-SETTLE
    start_frame();
    for (int i = 0; i < 5; i++) pixel(i);
    i_enable = 1'b0;
    tick();
    check("drop_busy", {287'd0, o_busy}, 288'd0);
    check("drop_valid", {287'd0, o_result_valid}, 288'd1);
    check("drop_result", {256'd0, o_result}, {256'd0, 32'h33333330});
    check("drop_frame", {272'd0, o_frame_count}, 288'd5);
    i_ctrl_bus = BUS_A; i_ctrl_update = 1'b1;
    tick();
    i_ctrl_update = 1'b0;
    check("drop_idle_load", o_ctrl_shadow, BUS_A);
    i_enable = 1'b1;
    tick();
    i_sof = 1'b1;
    tick();
    i_sof = 1'b0;
    check("rearm_flush", {287'd0, o_flush}, 288'd1);
    tick();
    tick();
    for (int i = 0; i < 16; i++) pixel(i);
    tick();
    tick();
    check("settle_busy", {287'd0, o_busy}, 288'd1);
    #2;
    i_rstn = 1'b0;
    #1;
    check("arst_shadow", o_ctrl_shadow, '0);
    check("arst_valid", {287'd0, o_result_valid}, 288'd0);
    check("arst_result", {256'd0, o_result}, 288'd0);
    check("arst_frame", {272'd0, o_frame_count}, 288'd0);
    check("arst_busy", {287'd0, o_busy}, 288'd0);
    check("arst_error", {284'd0, o_error}, 288'd0);
    #20;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
